// File: rtl/sprite_blitter_pkg.sv
// Shared types and constants for the sprite blitter: command word layout,
// descriptor layout and the control state encoding.
package sprite_blitter_pkg;

    // Magic value that requests a buffer swap instead of a sprite draw
    localparam logic [7:0] CMD_DO_RENDER = 8'hFF;
    // Bit position of the horizontal-mirror flag in the command flags
    localparam int         FLAG_FLIP_X   = 0;

    // 48-bit render-queue command word
    typedef struct packed {
        logic [7:0]         magic;
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [7:0]         flags;
    } cmd_t;

    // Descriptor entry as written by the host, shown at the default
    // SPRITE_AW=18 / COORD_W=16 sizes: {base, w, h}
    typedef struct packed {
        logic [17:0] base;
        logic [15:0] w;
        logic [15:0] h;
    } desc_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        DRAW,
        WAIT_VSYNC,
        SWAP
    } state_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Bus bundle between the blitter and its surroundings: render queue,
// descriptor write port, sprite ROM, back framebuffer and field timing.
interface sprite_blitter_if #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int PIX_W     = 24,
    parameter int N_SPRITES = 16,
    parameter int SPRITE_AW = 18,
    parameter int COORD_W   = 16
);
    localparam int IDX_W  = $clog2(N_SPRITES);
    localparam int FB_AW  = $clog2(SCREEN_W * SCREEN_H);
    localparam int DESC_W = SPRITE_AW + 2 * COORD_W;

    logic [47:0]          cmd_dout;
    logic                 cmd_empty;
    logic                 cmd_pop;
    logic                 desc_we;
    logic [IDX_W-1:0]     desc_waddr;
    logic [DESC_W-1:0]    desc_wdata;
    logic [SPRITE_AW-1:0] sprite_addr;
    logic [PIX_W-1:0]     sprite_din;
    logic                 fb_we;
    logic                 fb_sel;
    logic [FB_AW-1:0]     fb_addr;
    logic [PIX_W-1:0]     fb_din;
    logic                 end_of_field;
    logic                 front_buf;
    logic                 busy;
    logic                 bad_cmd;

    // Blitter side
    modport master (
        input  cmd_dout, cmd_empty, desc_we, desc_waddr, desc_wdata,
               sprite_din, end_of_field,
        output cmd_pop, sprite_addr, fb_we, fb_sel, fb_addr, fb_din,
               front_buf, busy, bad_cmd
    );

    // Environment side (queue, host, ROM, framebuffer, VGA timing)
    modport slave (
        output cmd_dout, cmd_empty, desc_we, desc_waddr, desc_wdata,
               sprite_din, end_of_field,
        input  cmd_pop, sprite_addr, fb_we, fb_sel, fb_addr, fb_din,
               front_buf, busy, bad_cmd
    );

endinterface

// File: rtl/sprite_blitter_desc_table.sv
// Host-loadable sprite descriptor table: one synchronous write port and one
// combinational read port. A read in the same cycle as a write to the same
// entry returns the old contents.
module sprite_desc_table #(
    parameter int N_SPRITES = 16,
    parameter int DESC_W    = 50,
    parameter int IDX_W     = $clog2(N_SPRITES)
) (
    input  logic              clk50,
    input  logic              reset_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DESC_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DESC_W-1:0] o_rdata
);

    logic [DESC_W-1:0] r_mem [N_SPRITES];

    // Table storage; cleared on reset so undefined sprites have zero size
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter top: pops draw commands, looks up sprite geometry, streams
// ROM pixels into the back framebuffer with clipping and horizontal flip,
// and swaps front/back buffers on end of field.
// Optional macro BLIT_TRANSPARENCY_EN: skip pixels equal to TRANSPARENT_KEY.
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int               SCREEN_W        = 640,
    parameter int               SCREEN_H        = 480,
    parameter int               PIX_W           = 24,
    parameter int               N_SPRITES       = 16,
    parameter int               SPRITE_AW       = 18,
    parameter int               COORD_W         = 16,
    parameter logic [PIX_W-1:0] TRANSPARENT_KEY = 24'hFF00FF
) (
    input  logic             clk50,
    input  logic             reset_n,
    sprite_blitter_if.master bus
);

    localparam int IDX_W  = $clog2(N_SPRITES);
    localparam int FB_AW  = $clog2(SCREEN_W * SCREEN_H);
    localparam int DESC_W = SPRITE_AW + 2 * COORD_W;
    // Screen position width: origin is COORD_W+1 bits, plus headroom for +w
    localparam int P_W    = COORD_W + 2;
    localparam logic signed [P_W-1:0] SCR_W_S = P_W'(SCREEN_W);
    localparam logic signed [P_W-1:0] SCR_H_S = P_W'(SCREEN_H);

    state_t r_state, w_next;
    logic   w_pop, w_bad;
    logic   r_front;
    cmd_t   w_cmd;

    // Latched command
    logic [IDX_W-1:0]          r_idx;
    logic signed [COORD_W-1:0] r_x, r_y;
    logic                      r_flip;

    // Descriptor read
    logic [DESC_W-1:0]         w_desc;
    logic [SPRITE_AW-1:0]      w_base;
    logic [COORD_W-1:0]        w_dw, w_dh;
    logic signed [COORD_W:0]   w_ox, w_oy;

    // Draw stage: source pixel being addressed this cycle
    logic [COORD_W-1:0]        r_w_p0, r_h_p0, r_cx_p0, r_cy_p0;
    logic [SPRITE_AW-1:0]      r_row_p0, r_sprite_addr_p0;
    logic signed [P_W-1:0]     r_ox_p0, r_px_p0, r_py_p0;
    logic                      r_drain_p0;
    logic                      w_eol, w_inb;
    logic [SPRITE_AW-1:0]      w_col0, w_next_row;
    logic [FB_AW-1:0]          w_fb_lin;

    // Write stage: ROM data for the pixel arrives alongside these
    logic                      r_vld_p1;
    logic [FB_AW-1:0]          r_fb_addr_p1;

    assign w_cmd = cmd_t'(bus.cmd_dout);

    sprite_desc_table #(
        .N_SPRITES (N_SPRITES),
        .DESC_W    (DESC_W),
        .IDX_W     (IDX_W)
    ) u_desc (
        .clk50   (clk50),
        .reset_n (reset_n),
        .i_we    (bus.desc_we),
        .i_waddr (bus.desc_waddr),
        .i_wdata (bus.desc_wdata),
        .i_raddr (r_idx),
        .o_rdata (w_desc)
    );

    assign w_base = w_desc[DESC_W-1 -: SPRITE_AW];
    assign w_dw   = w_desc[2*COORD_W-1:COORD_W];
    assign w_dh   = w_desc[COORD_W-1:0];

    // Sprite origin = centre minus half size, in COORD_W+1 signed bits
    assign w_ox = (COORD_W+1)'(r_x) - $signed({2'b00, w_dw[COORD_W-1:1]});
    assign w_oy = (COORD_W+1)'(r_y) - $signed({2'b00, w_dh[COORD_W-1:1]});

    assign w_eol      = (r_cx_p0 == r_w_p0 - COORD_W'(1));
    assign w_col0     = r_flip ? SPRITE_AW'(r_w_p0 - COORD_W'(1)) : '0;
    assign w_next_row = r_row_p0 + SPRITE_AW'(r_w_p0);
    assign w_inb      = !r_px_p0[P_W-1] && (r_px_p0 < SCR_W_S) &&
                        !r_py_p0[P_W-1] && (r_py_p0 < SCR_H_S);
    // Only meaningful when in bounds, where both terms are small positives
    assign w_fb_lin   = FB_AW'(r_py_p0) * FB_AW'(SCREEN_W) + FB_AW'(r_px_p0);

    // Control state register
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and single-cycle control strobes
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_bad  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!bus.cmd_empty) w_next = FETCH;
            end
            FETCH: begin
                w_pop = 1'b1;
                if (w_cmd.magic == CMD_DO_RENDER) begin
                    w_next = WAIT_VSYNC;
                end else if (int'(w_cmd.magic) >= N_SPRITES) begin
                    w_bad  = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                w_next = (w_dw == '0 || w_dh == '0) ? IDLE : DRAW;
            end
            DRAW: begin
                if (r_drain_p0) w_next = IDLE;
            end
            WAIT_VSYNC: begin
                if (bus.end_of_field) w_next = SWAP;
            end
            SWAP: begin
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Command latch, descriptor latch, pixel walk and write-stage pipeline
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_front           <= 1'b0;
            r_idx             <= '0;
            r_x               <= '0;
            r_y               <= '0;
            r_flip            <= 1'b0;
            r_w_p0            <= '0;
            r_h_p0            <= '0;
            r_cx_p0           <= '0;
            r_cy_p0           <= '0;
            r_row_p0          <= '0;
            r_sprite_addr_p0  <= '0;
            r_ox_p0           <= '0;
            r_px_p0           <= '0;
            r_py_p0           <= '0;
            r_drain_p0        <= 1'b0;
            r_vld_p1          <= 1'b0;
            r_fb_addr_p1      <= '0;
        end else begin
            r_vld_p1 <= 1'b0;

            if (r_state == FETCH) begin
                r_idx  <= w_cmd.magic[IDX_W-1:0];
                r_x    <= w_cmd.x;
                r_y    <= w_cmd.y;
                r_flip <= w_cmd.flags[FLAG_FLIP_X];
            end

            if (r_state == SETUP) begin
                r_w_p0           <= w_dw;
                r_h_p0           <= w_dh;
                r_cx_p0          <= '0;
                r_cy_p0          <= '0;
                r_row_p0         <= w_base;
                r_sprite_addr_p0 <= w_base +
                                    (r_flip ? SPRITE_AW'(w_dw - COORD_W'(1)) : '0);
                r_ox_p0          <= P_W'(w_ox);
                r_px_p0          <= P_W'(w_ox);
                r_py_p0          <= P_W'(w_oy);
                r_drain_p0       <= 1'b0;
            end

            // ---- draw stage -> write stage ----
            if (r_state == DRAW && !r_drain_p0) begin
                r_vld_p1 <= w_inb;
                if (w_inb) r_fb_addr_p1 <= w_fb_lin;
                if (w_eol) begin
                    r_cx_p0          <= '0;
                    r_cy_p0          <= r_cy_p0 + COORD_W'(1);
                    r_row_p0         <= w_next_row;
                    r_sprite_addr_p0 <= w_next_row + w_col0;
                    r_px_p0          <= r_ox_p0;
                    r_py_p0          <= r_py_p0 + P_W'(1);
                    if (r_cy_p0 == r_h_p0 - COORD_W'(1)) r_drain_p0 <= 1'b1;
                end else begin
                    r_cx_p0          <= r_cx_p0 + COORD_W'(1);
                    r_sprite_addr_p0 <= r_flip ? r_sprite_addr_p0 - SPRITE_AW'(1)
                                               : r_sprite_addr_p0 + SPRITE_AW'(1);
                    r_px_p0          <= r_px_p0 + P_W'(1);
                end
            end

            if (r_state == SWAP) r_front <= ~r_front;
        end
    end

`ifdef BLIT_TRANSPARENCY_EN
    assign bus.fb_we = r_vld_p1 && (bus.sprite_din != TRANSPARENT_KEY);
`else
    assign bus.fb_we = r_vld_p1;
    // The key colour only matters when transparency is compiled in
    logic w_unused_key;
    assign w_unused_key = ^TRANSPARENT_KEY;
`endif

    // Flag bits other than flip_x are reserved
    logic w_unused_flags;
    assign w_unused_flags = ^w_cmd.flags[7:1];

    assign bus.fb_din      = r_vld_p1 ? bus.sprite_din : '0;
    assign bus.fb_addr     = r_fb_addr_p1;
    assign bus.sprite_addr = r_sprite_addr_p0;
    assign bus.fb_sel      = ~r_front;
    assign bus.front_buf   = r_front;
    assign bus.busy        = (r_state != IDLE);
    assign bus.cmd_pop     = w_pop;
    assign bus.bad_cmd     = w_bad;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: placement, flip, clipping, zero-size,
// bad command, buffer swap, transparency and reset during a draw.
`timescale 1ns/1ps
module tb_sprite_blitter;

    localparam int          SW  = 640;
    localparam logic [23:0] KEY = 24'hFF00FF;
`ifdef BLIT_TRANSPARENCY_EN
    localparam bit TR_EN = 1'b1;
`else
    localparam bit TR_EN = 1'b0;
`endif

    logic clk50 = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk50 = ~clk50;

    sprite_blitter_if bus ();

    sprite_blitter dut (
        .clk50   (clk50),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Registered sprite ROM model: data one cycle after the address
    logic [23:0] rom [64];
    always @(posedge clk50) bus.sprite_din <= rom[bus.sprite_addr[5:0]];

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    // Activity log sampled away from the active edge
    int q_addr[$];
    int q_data[$];
    int q_cyc[$];
    int pop_cyc  = -1;
    int bad_cnt  = 0;
    int busy_cnt = 0;
    always @(negedge clk50) begin
        if (bus.fb_we) begin
            q_addr.push_back(int'(bus.fb_addr));
            q_data.push_back(int'(bus.fb_din));
            q_cyc.push_back(cyc);
        end
        if (bus.cmd_pop) pop_cyc <= cyc;
        if (bus.bad_cmd) bad_cnt <= bad_cnt + 1;
        if (bus.busy)    busy_cnt <= busy_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;
    int wr_base, busy_base, bad_base;
    int exp_addr[$];
    int exp_data[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_logs();
        @(posedge clk50);
        #1;
        wr_base   = q_addr.size();
        busy_base = busy_cnt;
        bad_base  = bad_cnt;
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic write_desc(input int idx, input int base, input int w, input int h);
        @(negedge clk50);
        bus.desc_we    = 1'b1;
        bus.desc_waddr = 4'(idx);
        bus.desc_wdata = {18'(base), 16'(w), 16'(h)};
        @(negedge clk50);
        bus.desc_we    = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] m, input logic signed [15:0] x,
                            input logic signed [15:0] y, input logic [7:0] f);
        int n;
        n = 0;
        @(negedge clk50);
        bus.cmd_dout  = {m, x, y, f};
        bus.cmd_empty = 1'b0;
        do begin
            @(negedge clk50);
            n++;
        end while (!bus.cmd_pop && n < 10);
        chk($sformatf("pop_%0h", m), bus.cmd_pop, 1);
        bus.cmd_empty = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk50);
            n++;
        end
        chk({tag, "_idle"}, bus.busy, 0);
        @(posedge clk50);
        #1;
    endtask

    task automatic check_writes(input string tag);
        int n;
        n = q_addr.size() - wr_base;
        chk({tag, "_cnt"}, n, exp_addr.size());
        for (int i = 0; i < n && i < exp_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), q_addr[wr_base+i], exp_addr[i]);
            chk($sformatf("%s_data%0d", tag, i), q_data[wr_base+i], exp_data[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, low, snap;
        bus.cmd_dout     = '0;
        bus.cmd_empty    = 1'b1;
        bus.desc_we      = 1'b0;
        bus.desc_waddr   = '0;
        bus.desc_wdata   = '0;
        bus.end_of_field = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 24'h110000 + 24'(i);
        rom[17] = KEY;

        reset_n = 1'b0;
        repeat (3) @(negedge clk50);
        chk("rst_busy",   bus.busy, 0);
        chk("rst_front",  bus.front_buf, 0);
        chk("rst_fbsel",  bus.fb_sel, 1);
        chk("rst_we",     bus.fb_we, 0);
        chk("rst_pop",    bus.cmd_pop, 0);
        chk("rst_bad",    bus.bad_cmd, 0);
        chk("rst_saddr",  bus.sprite_addr, 0);
        chk("rst_faddr",  bus.fb_addr, 0);
        chk("rst_fdin",   bus.fb_din, 0);
        reset_n = 1'b1;

        // Plain 4x2 sprite centred at (100,50): origin (98,49)
        write_desc(0, 0, 4, 2);
        clear_logs();
        send_cmd(8'h00, 16'sd100, 16'sd50, 8'h00);
        wait_idle("t1", 100);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                exp_addr.push_back((49 + r) * SW + 98 + c);
                exp_data.push_back(int'(rom[r*4+c]));
            end
        check_writes("t1");
        lat = (q_cyc.size() > wr_base) ? q_cyc[wr_base] - pop_cyc : -1;
        chk("t1_latency", lat, 3);
        chk("t1_busy", busy_cnt - busy_base, 11);

        // Same sprite mirrored
        clear_logs();
        send_cmd(8'h00, 16'sd100, 16'sd50, 8'h01);
        wait_idle("t2", 100);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                exp_addr.push_back((49 + r) * SW + 98 + c);
                exp_data.push_back(int'(rom[r*4+3-c]));
            end
        check_writes("flip");

        // Top-left clip: origin (-1,-1), only row 0 cols 0..2 survive
        clear_logs();
        send_cmd(8'h00, 16'sd1, 16'sd0, 8'h00);
        wait_idle("t3", 100);
        for (int c = 1; c < 4; c++) begin
            exp_addr.push_back(c - 1);
            exp_data.push_back(int'(rom[4+c]));
        end
        check_writes("clip");

        // Zero-width descriptor: no writes, FETCH+SETUP only
        write_desc(1, 0, 0, 3);
        clear_logs();
        send_cmd(8'h01, 16'sd100, 16'sd50, 8'h00);
        wait_idle("t4", 100);
        check_writes("zero");
        chk("zero_busy", busy_cnt - busy_base, 2);

        // Out-of-range sprite index
        clear_logs();
        send_cmd(8'h20, 16'sd100, 16'sd50, 8'h00);
        wait_idle("t5", 100);
        chk("bad_pulses", bad_cnt - bad_base, 1);
        check_writes("bad");
        chk("bad_busy", busy_cnt - busy_base, 1);

        // End of field while idle must not swap
        @(negedge clk50);
        bus.end_of_field = 1'b1;
        @(negedge clk50);
        bus.end_of_field = 1'b0;
        repeat (3) @(negedge clk50);
        chk("eof_idle_front", bus.front_buf, 0);

        // Swap request: wait 200 cycles, then pulse end of field
        clear_logs();
        send_cmd(8'hFF, 16'sd0, 16'sd0, 8'h00);
        low = 0;
        repeat (200) begin
            @(negedge clk50);
            if (!bus.busy) low++;
        end
        chk("vs_busy_low", low, 0);
        chk("vs_front_hold", bus.front_buf, 0);
        bus.end_of_field = 1'b1;
        @(negedge clk50);
        bus.end_of_field = 1'b0;
        chk("vs_front_1cyc", bus.front_buf, 0);
        @(negedge clk50);
        chk("vs_front_2cyc", bus.front_buf, 1);
        chk("vs_fbsel", bus.fb_sel, 0);
        wait_idle("t6", 10);

        // Key-coloured pixel: skipped only with transparency compiled in
        write_desc(2, 16, 4, 1);
        clear_logs();
        send_cmd(8'h02, 16'sd100, 16'sd50, 8'h00);
        wait_idle("t7", 100);
        for (int c = 0; c < 4; c++) begin
            if (!(TR_EN && rom[16+c] == KEY)) begin
                exp_addr.push_back(50 * SW + 98 + c);
                exp_data.push_back(int'(rom[16+c]));
            end
        end
        check_writes("key");

        // Reset in the middle of an 8x8 draw
        write_desc(3, 0, 8, 8);
        clear_logs();
        send_cmd(8'h03, 16'sd100, 16'sd100, 8'h00);
        low = 0;
        while (q_addr.size() == wr_base && low < 20) begin
            @(negedge clk50);
            low++;
        end
        chk("rm_started", q_addr.size() > wr_base, 1);
        @(posedge clk50);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rm_we",    bus.fb_we, 0);
        chk("rm_front", bus.front_buf, 0);
        chk("rm_busy",  bus.busy, 0);
        snap = q_addr.size();
        repeat (3) @(negedge clk50);
        chk("rm_no_writes", q_addr.size(), snap);
        @(negedge clk50);
        reset_n = 1'b1;

        // Table was cleared by reset: entry 0 is now zero-sized
        clear_logs();
        send_cmd(8'h00, 16'sd100, 16'sd50, 8'h00);
        wait_idle("t8", 100);
        check_writes("clr");
        chk("clr_busy", busy_cnt - busy_base, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
